// File: rtl/dft_phase_gen_pkg.sv
// Shared types and constants for the DFT phase/address generator.
// Holds the FSM state encoding, default widths and the quarter-cycle offset.
package dft_phase_gen_pkg;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_NPTS_LOG2 = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Quarter of a sine period in LUT entries: turns a sine address into a cosine one.
  function automatic int quarter_off(input int aw);
    return 1 << (aw - 2);
  endfunction

  localparam int QTR_OFF = quarter_off(DEF_ADDR_W);

endpackage

// File: rtl/dft_phase_acc.sv
// Phase accumulator: modulo-2^W running sum of step, with synchronous clear.
// Latency: 1 cycle from clr/en to phase; no backpressure of its own, en gates updates.
// Clear has priority over enable.
module dft_phase_acc
  import dft_phase_gen_pkg::*;
#(
  parameter int W = DEF_ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] step,
  output logic [W-1:0] phase
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + step;
    end
  end

endmodule

// File: rtl/dft_phase_gen.sv
// Sweeps DFT bins k=bin_first..bin_last, n=0..N-1, emitting sine/cosine LUT addresses (k*n) mod 2^ADDR_W.
// Latency: first point one cycle after an accepted start, then one point per cycle.
// Backpressure: all registered outputs hold while valid && !ready.
module dft_phase_gen
  import dft_phase_gen_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NPTS_LOG2 = DEF_NPTS_LOG2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    bin_first,
  input  logic [ADDR_W-1:0]    bin_last,
  input  logic                 ready,
  output logic [ADDR_W-1:0]    sin_addr,
  output logic [ADDR_W-1:0]    cos_addr,
  output logic [ADDR_W-1:0]    bin_idx,
  output logic [NPTS_LOG2-1:0] samp_idx,
  output logic                 valid,
  output logic                 first_samp,
  output logic                 last_samp,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [ADDR_W-1:0]    QTR    = ADDR_W'(quarter_off(ADDR_W));
  localparam logic [NPTS_LOG2-1:0] N_LAST = '1;

  state_t            state;
  logic [ADDR_W-1:0] k_last;
  logic [ADDR_W-1:0] phase;
  logic              xfer;
  logic              pt_last;
  logic              bin_end;
  logic              accept;
  logic              acc_clr;
  logic              acc_en;

  assign xfer    = valid && ready;
  assign pt_last = (samp_idx == N_LAST);
  assign bin_end = (bin_idx == k_last);
  assign accept  = (state == ST_IDLE) && start && (bin_first <= bin_last);

  // Phase restarts at zero at every bin boundary, so k*n never needs a multiplier.
  assign acc_clr = accept || ((state == ST_RUN) && xfer && pt_last);
  assign acc_en  = (state == ST_RUN) && xfer && !pt_last;

  dft_phase_acc #(
    .W (ADDR_W)
  ) u_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .en    (acc_en),
    .step  (bin_idx),
    .phase (phase)
  );

  assign sin_addr = phase;
  assign cos_addr = phase + QTR;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      k_last     <= '0;
      bin_idx    <= '0;
      samp_idx   <= '0;
      valid      <= 1'b0;
      first_samp <= 1'b0;
      last_samp  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (bin_first <= bin_last) begin
              state      <= ST_RUN;
              bin_idx    <= bin_first;
              k_last     <= bin_last;
              samp_idx   <= '0;
              valid      <= 1'b1;
              first_samp <= 1'b1;
              last_samp  <= 1'b0;
              busy       <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            if (!pt_last) begin
              samp_idx   <= samp_idx + 1'b1;
              first_samp <= 1'b0;
              last_samp  <= (samp_idx == N_LAST - 1'b1);
            end else if (!bin_end) begin
              bin_idx    <= bin_idx + 1'b1;
              samp_idx   <= '0;
              first_samp <= 1'b1;
              last_samp  <= 1'b0;
            end else begin
              state      <= ST_DONE;
              valid      <= 1'b0;
              first_samp <= 1'b0;
              last_samp  <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dft_phase_gen.sv
// Scoreboard bench for dft_phase_gen: expected (k,n,sin,cos) points are queued at start
// and popped as the DUT transfers them.
module tb_dft_phase_gen;

  localparam int AW = 10;
  localparam int NL = 10;
  localparam int N  = 1 << NL;
  localparam int M  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] bin_first;
  logic [AW-1:0] bin_last;
  logic          ready;
  logic [AW-1:0] sin_addr;
  logic [AW-1:0] cos_addr;
  logic [AW-1:0] bin_idx;
  logic [NL-1:0] samp_idx;
  logic          valid;
  logic          first_samp;
  logic          last_samp;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  dft_phase_gen #(
    .ADDR_W    (AW),
    .NPTS_LOG2 (NL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bin_first  (bin_first),
    .bin_last   (bin_last),
    .ready      (ready),
    .sin_addr   (sin_addr),
    .cos_addr   (cos_addr),
    .bin_idx    (bin_idx),
    .samp_idx   (samp_idx),
    .valid      (valid),
    .first_samp (first_samp),
    .last_samp  (last_samp),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    int k;
    int n;
    int s;
    int c;
    bit f;
    bit l;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push_sweep(input int bf, input int bl);
    for (int k = bf; k <= bl; k++) begin
      for (int n = 0; n < N; n++) begin
        exp_t e;
        e.k = k;
        e.n = n;
        e.s = (k * n) % M;
        e.c = (e.s + M / 4) % M;
        e.f = (n == 0);
        e.l = (n == N - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_idle(input string name, input bit want_done);
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== want_done || err !== 1'b0) begin
      fails++;
      $display("FAIL %s: valid=%b busy=%b done=%b err=%b, want valid=0 busy=0 done=%b err=0",
               name, valid, busy, done, err, want_done);
    end
  endtask

  // Called at a falling edge; start is raised immediately for the next rising edge.
  task automatic run_sweep(input string name, input int bf, input int bl,
                           input int stall_k, input int stall_n, input int stall_len,
                           input int inj_n);
    int   nexp;
    int   cycles;
    int   stalls;
    int   budget;
    exp_t e;
    push_sweep(bf, bl);
    nexp   = exp_q.size();
    stalls = stall_len;
    cycles = 0;
    budget = nexp + stall_len + 20;
    bin_first = AW'(bf);
    bin_last  = AW'(bl);
    start     = 1'b1;
    ready     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (exp_q.size() > 0 && cycles < budget) begin
      cycles++;
      e = exp_q[0];
      if (inj_n >= 0 && valid && int'(samp_idx) == inj_n && int'(bin_idx) == bf) begin
        start     = 1'b1;
        bin_first = AW'(9);
        bin_last  = AW'(4);
      end else begin
        start = 1'b0;
      end
      if (valid && int'(bin_idx) == stall_k && int'(samp_idx) == stall_n && stalls > 0) begin
        ready = 1'b0;
        stalls--;
      end else begin
        ready = 1'b1;
      end
      tests++;
      if (valid !== 1'b1 || busy !== 1'b1 || err !== 1'b0 ||
          bin_idx !== AW'(e.k) || samp_idx !== NL'(e.n) ||
          sin_addr !== AW'(e.s) || cos_addr !== AW'(e.c) ||
          first_samp !== e.f || last_samp !== e.l) begin
        fails++;
        $display("FAIL %s point: got v=%b busy=%b err=%b k=%0d n=%0d sin=%0d cos=%0d f=%b l=%b, want v=1 busy=1 err=0 k=%0d n=%0d sin=%0d cos=%0d f=%b l=%b",
                 name, valid, busy, err, bin_idx, samp_idx, sin_addr, cos_addr, first_samp,
                 last_samp, e.k, e.n, e.s, e.c, e.f, e.l);
      end
      if (ready) void'(exp_q.pop_front());
      @(negedge clk);
    end
    start = 1'b0;
    ready = 1'b1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s timeout: %0d points outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
    tests++;
    if (cycles != nexp + stall_len) begin
      fails++;
      $display("FAIL %s cycles: got %0d, want %0d", name, cycles, nexp + stall_len);
    end
    check_idle({name, " done_pulse"}, 1'b1);
    @(negedge clk);
    check_idle({name, " done_clear"}, 1'b0);
  endtask

  task automatic check_reset_vals(input string name);
    tests++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        first_samp !== 1'b0 || last_samp !== 1'b0 || sin_addr !== '0 ||
        cos_addr !== AW'(M / 4) || bin_idx !== '0 || samp_idx !== '0) begin
      fails++;
      $display("FAIL %s: v=%b busy=%b done=%b err=%b f=%b l=%b sin=%0d cos=%0d k=%0d n=%0d, want all 0 and cos=%0d",
               name, valid, busy, done, err, first_samp, last_samp, sin_addr, cos_addr,
               bin_idx, samp_idx, M / 4);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b1;
    ready     = 1'b1;
    bin_first = AW'(1);
    bin_last  = AW'(2);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_err();
    bin_first = AW'(9);
    bin_last  = AW'(4);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (err !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse: err=%b valid=%b busy=%b, want err=1 valid=0 busy=0", err, valid, busy);
    end
    @(negedge clk);
    check_idle("err_clear", 1'b0);
  endtask

  task automatic test_reset_mid();
    int guard;
    bin_first = AW'(4);
    bin_last  = AW'(4);
    start     = 1'b1;
    ready     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(valid && int'(samp_idx) == 500) && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
    tests++;
    if (guard >= 1000) begin
      fails++;
      $display("FAIL reset_mid reach: n=%0d after %0d cycles, want n=500", samp_idx, guard);
    end
    tests++;
    if (sin_addr !== AW'((4 * 500) % M)) begin
      fails++;
      $display("FAIL reset_mid phase: sin=%0d, want %0d", sin_addr, (4 * 500) % M);
    end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_reset_vals("reset_mid");
    reset = 1'b0;
    run_sweep("after_reset", 4, 4, -1, -1, 0, -1);
  endtask

  initial begin
    test_reset();
    run_sweep("single_k1", 1, 1, -1, -1, 0, -1);
    run_sweep("k3", 3, 3, -1, -1, 0, -1);
    run_sweep("multi_5_7", 5, 7, -1, -1, 0, 10);
    run_sweep("backpressure", 2, 2, 2, 100, 4, -1);
    run_sweep("dc_bin", 0, 0, -1, -1, 0, -1);
    test_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
